// File: rtl/hart_dm_bridge.sv
// rtl/hart_dm_bridge.sv - hart-side bridge between the Debug Module and the hart debug unit
//
// Purpose:
//   Converts DM halt requests into a debug interrupt request.
//   Converts DM resume requests into a one-cycle resume pulse.
//   Runs DM abstract register commands on the debug CSRs while the hart is halted.
//   Reports halted, running and resumeack status back to the DM.
//
// Ports:
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   dm_haltreq_i          DM halt request (level)
//   dm_resumereq_i        DM resume request (rising edge significant)
//   dm_cmd_*              abstract command handshake and fields (write, regno, wdata)
//   dm_rsp_*              one-cycle response: valid, rdata, cmderr
//   dm_halted_o           hart halted status
//   dm_running_o          hart running status
//   dm_resumeack_o        sticky resume acknowledge
//   dm_haltto_o           sticky halt-timeout flag
//   halted_i, run_i       hart debug unit state
//   debug_intreq_o        debug interrupt request to the commit stage
//   resumereq_o           resume pulse to the hart debug unit
//   debug_csr*_o          debug CSR write port; the index also addresses reads
//   csr_rdata_i           combinational CSR value at debug_csrindex_o
module hart_dm_bridge #(
  parameter int XLEN = 64,
  parameter int TO_W = 10
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            dm_haltreq_i,
  input  logic            dm_resumereq_i,
  input  logic            dm_cmd_valid_i,
  output logic            dm_cmd_ready_o,
  input  logic            dm_cmd_write_i,
  input  logic [11:0]     dm_cmd_regno_i,
  input  logic [XLEN-1:0] dm_cmd_wdata_i,
  output logic            dm_rsp_valid_o,
  output logic [XLEN-1:0] dm_rsp_rdata_o,
  output logic [2:0]      dm_rsp_err_o,
  output logic            dm_halted_o,
  output logic            dm_running_o,
  output logic            dm_resumeack_o,
  output logic            dm_haltto_o,
  input  logic            halted_i,
  input  logic            run_i,
  output logic            debug_intreq_o,
  output logic            resumereq_o,
  output logic            debug_csren_o,
  output logic [11:0]     debug_csrindex_o,
  output logic [XLEN-1:0] debug_csrdata_o,
  input  logic [XLEN-1:0] csr_rdata_i
);

  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_HALT   = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_CMD,
    ST_RESUMING
  } state_t;

  state_t state_q, state_d;

  logic            resume_prev_q;
  logic            resume_pend_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            cmd_write_q;
  logic [11:0]     cmd_regno_q;
  logic [XLEN-1:0] cmd_wdata_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic [2:0]      rsp_err_q;
  logic            resumeack_q;

  logic resume_edge;
  logic resume_go;
  logic cmd_accept;
  logic regno_ok;
  logic regno_rw;
  logic cmd_bad;

  assign resume_edge = dm_resumereq_i & ~resume_prev_q;
  assign regno_ok    = cmd_regno_q inside {CSR_DCSR, CSR_DPC, CSR_DSCRATCH0, CSR_DSCRATCH1};
  assign regno_rw    = (cmd_regno_q == CSR_DCSR) || (cmd_regno_q == CSR_DPC);
  assign cmd_bad     = !regno_ok || (cmd_write_q && !regno_rw);
  assign cmd_accept  = dm_cmd_valid_i & dm_cmd_ready_o;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    dm_cmd_ready_o   = 1'b0;
    debug_intreq_o   = 1'b0;
    resumereq_o      = 1'b0;
    resume_go        = 1'b0;
    debug_csren_o    = 1'b0;
    debug_csrindex_o = '0;
    debug_csrdata_o  = '0;
    case (state_q)
      ST_RUN: begin
        debug_intreq_o = dm_haltreq_i;
        // Outside HALTED a command is taken immediately and refused with err=4,
        // so ready simply follows valid (and stays low when idle).
        dm_cmd_ready_o = dm_cmd_valid_i;
        if (halted_i) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        dm_cmd_ready_o = 1'b1;
        if (dm_cmd_valid_i) begin
          state_d = ST_CMD;
        end else if (!dm_haltreq_i &&
                     (resume_edge || (resume_pend_q && !rsp_valid_q))) begin
          // A resume held back by a command goes out one cycle after its response.
          resume_go   = 1'b1;
          resumereq_o = 1'b1;
          state_d     = ST_RESUMING;
        end
      end
      ST_CMD: begin
        // Busy for one cycle; a new command waits until HALTED is back.
        debug_csrindex_o = cmd_regno_q;
        debug_csrdata_o  = cmd_wdata_q;
        debug_csren_o    = cmd_write_q && regno_rw;
        state_d          = ST_HALTED;
      end
      ST_RESUMING: begin
        dm_cmd_ready_o = dm_cmd_valid_i;
        if (run_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      resume_prev_q <= 1'b0;
      resume_pend_q <= 1'b0;
      to_cnt_q      <= '0;
      cmd_write_q   <= 1'b0;
      cmd_regno_q   <= '0;
      cmd_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= ERR_NONE;
      resumeack_q   <= 1'b0;
    end else begin
      resume_prev_q <= dm_resumereq_i;
      rsp_valid_q   <= 1'b0;

      // Halt-timeout counter saturates at all-ones; that value is the sticky flag.
      if (!dm_haltreq_i) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_RUN && !halted_i && to_cnt_q != '1) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      case (state_q)
        ST_HALTED: begin
          if (cmd_accept) begin
            if (resume_edge) begin
              resume_pend_q <= 1'b1;
            end
          end else if (resume_go || !rsp_valid_q) begin
            resume_pend_q <= 1'b0;
          end
        end
        ST_CMD: begin
          if (resume_edge) begin
            resume_pend_q <= 1'b1;
          end
        end
        default: resume_pend_q <= 1'b0;
      endcase

      if (state_q == ST_HALTED && cmd_accept) begin
        cmd_write_q <= dm_cmd_write_i;
        cmd_regno_q <= dm_cmd_regno_i;
        cmd_wdata_q <= dm_cmd_wdata_i;
      end else if (state_q == ST_CMD) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cmd_bad ? ERR_NOTSUP : ERR_NONE;
        rsp_rdata_q <= (!cmd_bad && !cmd_write_q) ? csr_rdata_i : '0;
      end else if (cmd_accept) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= ERR_HALT;
        rsp_rdata_q <= '0;
      end

      if (resume_go) begin
        resumeack_q <= 1'b0;
      end else if (state_q == ST_RESUMING && run_i) begin
        resumeack_q <= 1'b1;
      end
    end
  end

  assign dm_rsp_valid_o = rsp_valid_q;
  assign dm_rsp_rdata_o = rsp_rdata_q;
  assign dm_rsp_err_o   = rsp_err_q;
  assign dm_halted_o    = (state_q == ST_HALTED) || (state_q == ST_CMD);
  assign dm_running_o   = (state_q == ST_RUN);
  assign dm_resumeack_o = resumeack_q;
  assign dm_haltto_o    = &to_cnt_q;

endmodule

// File: tb/tb_hart_dm_bridge.sv
// tb/tb_hart_dm_bridge.sv - self-checking bench for hart_dm_bridge
module tb_hart_dm_bridge;

  logic        clk = 1'b0;
  logic        arstn;
  logic        haltreq, resumereq, cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_regno;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        halted_o, running_o, resumeack_o, haltto_o;
  logic        halted_i, run_i;
  logic        intreq, resumereq_o, csren;
  logic [11:0] csrindex;
  logic [63:0] csrdata, csr_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hart_dm_bridge #(.XLEN(64), .TO_W(4)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .dm_haltreq_i(haltreq), .dm_resumereq_i(resumereq),
    .dm_cmd_valid_i(cmd_valid), .dm_cmd_ready_o(cmd_ready),
    .dm_cmd_write_i(cmd_write), .dm_cmd_regno_i(cmd_regno), .dm_cmd_wdata_i(cmd_wdata),
    .dm_rsp_valid_o(rsp_valid), .dm_rsp_rdata_o(rsp_rdata), .dm_rsp_err_o(rsp_err),
    .dm_halted_o(halted_o), .dm_running_o(running_o),
    .dm_resumeack_o(resumeack_o), .dm_haltto_o(haltto_o),
    .halted_i(halted_i), .run_i(run_i),
    .debug_intreq_o(intreq), .resumereq_o(resumereq_o),
    .debug_csren_o(csren), .debug_csrindex_o(csrindex), .debug_csrdata_o(csrdata),
    .csr_rdata_i(csr_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_halted"}, halted_o, 0);
    chk({tag, "_running"}, running_o, 1);
    chk({tag, "_resumeack"}, resumeack_o, 0);
    chk({tag, "_haltto"}, haltto_o, 0);
    chk({tag, "_intreq"}, intreq, 0);
    chk({tag, "_resumereq"}, resumereq_o, 0);
    chk({tag, "_csren"}, csren, 0);
    chk({tag, "_csrindex"}, csrindex, 0);
    chk({tag, "_csrdata"}, csrdata, 0);
  endtask

  typedef struct {
    logic        w;
    logic [11:0] regno;
    logic [63:0] wdata;
    logic [63:0] rd;
    logic        csren;
    logic [2:0]  err;
    logic [63:0] rdata;
  } vec_t;

  vec_t vt[8];

  // Command issued in HALTED: accept cycle, CMD cycle, response cycle, quiet cycle.
  task automatic run_vec(input vec_t v);
    cmd_valid = 1; cmd_write = v.w; cmd_regno = v.regno; cmd_wdata = v.wdata;
    csr_rdata = ~v.rd;
    #2;
    chk("vec_ready", cmd_ready, 1);
    chk("vec_csren_accept", csren, 0);
    tick();
    cmd_valid = 0; cmd_wdata = '0; csr_rdata = v.rd;
    #2;
    chk("vec_csren", csren, v.csren);
    chk("vec_csrindex", csrindex, v.regno);
    if (v.csren) chk("vec_csrdata", csrdata, v.wdata);
    chk("vec_halted_in_cmd", halted_o, 1);
    chk("vec_rsp_early", rsp_valid, 0);
    tick();
    csr_rdata = ~v.rd;
    #2;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_err", rsp_err, v.err);
    chk("vec_rsp_rdata", rsp_rdata, v.rdata);
    chk("vec_csren_after", csren, 0);
    tick();
    #2;
    chk("vec_rsp_pulse", rsp_valid, 0);
  endtask

  // Reference model: the hart-side debug protocol described as mode plus
  // outstanding-response bookkeeping.
  int          m_mode;      // 0 running, 1 halted, 2 resuming
  logic        m_incmd, m_cw;
  logic [11:0] m_creg;
  logic [63:0] m_cwd;
  logic        m_rsp, m_rsp_n;
  logic [2:0]  m_err, m_err_n;
  logic [63:0] m_rd, m_rd_n;
  logic        m_pend, m_prev, m_ack;
  int          m_wait;
  logic        e_edge, e_ready, e_resume, e_csren;

  function automatic logic [2:0] csr_err(input logic w, input logic [11:0] r);
    if (r < 12'h7B0 || r > 12'h7B3) return 3'd2;
    if (w && r > 12'h7B1) return 3'd2;
    return 3'd0;
  endfunction

  initial begin
    arstn = 0; haltreq = 0; resumereq = 0; cmd_valid = 0; cmd_write = 0;
    cmd_regno = 0; cmd_wdata = 0; halted_i = 0; run_i = 0; csr_rdata = 0;

    vt[0] = '{1'b1, 12'h7B1, 64'h8000_1000, 64'h0, 1'b1, 3'd0, 64'h0};
    vt[1] = '{1'b0, 12'h7B1, 64'h0, 64'h8000_1000, 1'b0, 3'd0, 64'h8000_1000};
    vt[2] = '{1'b1, 12'h7B2, 64'h1234, 64'h55, 1'b0, 3'd2, 64'h0};
    vt[3] = '{1'b0, 12'h300, 64'h0, 64'h77, 1'b0, 3'd2, 64'h0};
    vt[4] = '{1'b1, 12'h7B0, 64'h4000_0003, 64'h9, 1'b1, 3'd0, 64'h0};
    vt[5] = '{1'b0, 12'h7B3, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, 3'd0, 64'hDEAD_BEEF_0123_4567};
    vt[6] = '{1'b1, 12'h7B3, 64'hFFFF, 64'h1, 1'b0, 3'd2, 64'h0};
    vt[7] = '{1'b0, 12'h7B0, 64'h0, 64'hA5A5_0000_0000_5A5A, 1'b0, 3'd0, 64'hA5A5_0000_0000_5A5A};

    // Reset values, then held for 10 cycles after release.
    #3;
    chk_idle_outputs("reset");
    tick();
    arstn = 1;
    repeat (10) tick();
    #2;
    chk_idle_outputs("post_reset");

    // Halt: debug unit answers after 5 cycles.
    haltreq = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("halt_intreq", intreq, 1);
      chk("halt_not_yet", halted_o, 0);
      chk("halt_haltto", haltto_o, 0);
      tick();
    end
    halted_i = 1;
    #2;
    chk("halt_same_cycle", halted_o, 0);
    tick();
    #2;
    chk("halt_halted", halted_o, 1);
    chk("halt_running", running_o, 0);
    chk("halt_haltto_after", haltto_o, 0);
    chk("halt_intreq_off", intreq, 0);
    haltreq = 0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Halt request together with a resume edge: halt wins, nothing latched.
    haltreq = 1; resumereq = 1;
    #2;
    chk("haltwin_resumereq", resumereq_o, 0);
    tick();
    haltreq = 0; resumereq = 0;
    #2;
    chk("haltwin_halted", halted_o, 1);
    chk("haltwin_resumereq2", resumereq_o, 0);
    tick();
    #2;
    chk("haltwin_resumereq3", resumereq_o, 0);
    tick();

    // Command and resume edge together: response first, resume pulse next cycle.
    cmd_valid = 1; cmd_write = 0; cmd_regno = 12'h7B0; resumereq = 1;
    #2;
    chk("simul_resumereq_accept", resumereq_o, 0);
    tick();
    cmd_valid = 0;
    #2;
    chk("simul_resumereq_cmd", resumereq_o, 0);
    tick();
    #2;
    chk("simul_rsp_valid", rsp_valid, 1);
    chk("simul_resumereq_rsp", resumereq_o, 0);
    tick();
    #2;
    chk("simul_resumereq_pulse", resumereq_o, 1);
    halted_i = 0;
    tick();
    #2;
    chk("resume_pulse_single", resumereq_o, 0);
    chk("resume_halted", halted_o, 0);
    chk("resume_running", running_o, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      chk("resume_ack_wait", resumeack_o, 0);
    end
    run_i = 1;
    tick();
    #2;
    chk("resume_ack", resumeack_o, 1);
    chk("resume_run", running_o, 1);

    // Command while running is refused with err=4.
    cmd_valid = 1; cmd_write = 1; cmd_regno = 12'h7B1; cmd_wdata = 64'h42;
    #2;
    chk("run_cmd_ready", cmd_ready, 1);
    chk("run_cmd_csren", csren, 0);
    tick();
    cmd_valid = 0;
    #2;
    chk("run_cmd_rsp", rsp_valid, 1);
    chk("run_cmd_err", rsp_err, 4);
    chk("run_cmd_rdata", rsp_rdata, 0);
    chk("run_cmd_csren2", csren, 0);
    chk("run_cmd_state", running_o, 1);
    tick();

    // Halt timeout with a 4-bit counter: flag after 15 cycles, sticky, cleared by haltreq=0.
    haltreq = 1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      #2;
      chk("timeout_flag", haltto_o, (k >= 15) ? 1 : 0);
    end
    haltreq = 0;
    tick();
    #2;
    chk("timeout_clear", haltto_o, 0);

    // Reset in the middle of a command: no csren afterwards, no response.
    haltreq = 1; halted_i = 1;
    tick();
    haltreq = 0;
    #2;
    chk("rstcmd_halted", halted_o, 1);
    cmd_valid = 1; cmd_write = 1; cmd_regno = 12'h7B1; cmd_wdata = 64'h99;
    tick();
    cmd_valid = 0;
    #1;
    chk("rstcmd_csren_before", csren, 1);
    arstn = 0;
    #1;
    chk("rstcmd_csren", csren, 0);
    chk("rstcmd_running", running_o, 1);
    halted_i = 0; run_i = 0;
    tick();
    arstn = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rstcmd_no_rsp", rsp_valid, 0);
      chk("rstcmd_no_resume", resumereq_o, 0);
      tick();
    end

    // Randomized run against the reference model.
    arstn = 0;
    tick();
    arstn = 1;
    m_mode = 0; m_incmd = 0; m_cw = 0; m_creg = 0; m_cwd = 0;
    m_rsp = 0; m_err = 0; m_rd = 0; m_pend = 0; m_prev = 0; m_ack = 0; m_wait = 0;
    for (int c = 0; c < 600; c++) begin
      haltreq   = ($urandom_range(0, 3) == 0);
      resumereq = ($urandom_range(0, 2) == 0) ? ~resumereq : resumereq;
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_write = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: cmd_regno = 12'h7B0;
        1: cmd_regno = 12'h7B1;
        2: cmd_regno = 12'h7B2;
        3: cmd_regno = 12'h7B3;
        4: cmd_regno = 12'h300;
        default: cmd_regno = 12'($urandom);
      endcase
      cmd_wdata = {$urandom, $urandom};
      csr_rdata = {$urandom, $urandom};
      halted_i  = ($urandom_range(0, 5) == 0);
      run_i     = ($urandom_range(0, 2) == 0);
      #2;
      e_edge   = resumereq && !m_prev;
      e_ready  = m_incmd ? 1'b0 : (m_mode == 1) ? 1'b1 : cmd_valid;
      e_resume = (m_mode == 1) && !m_incmd && !cmd_valid && !haltreq &&
                 (e_edge || (m_pend && !m_rsp));
      e_csren  = m_incmd && m_cw && (m_creg == 12'h7B0 || m_creg == 12'h7B1);
      chk("rnd_halted", halted_o, (m_mode == 1) ? 1 : 0);
      chk("rnd_running", running_o, (m_mode == 0) ? 1 : 0);
      chk("rnd_intreq", intreq, (m_mode == 0 && haltreq) ? 1 : 0);
      chk("rnd_ready", cmd_ready, e_ready);
      chk("rnd_resumereq", resumereq_o, e_resume);
      chk("rnd_csren", csren, e_csren);
      if (e_csren) chk("rnd_csrdata", csrdata, m_cwd);
      chk("rnd_rsp_valid", rsp_valid, m_rsp);
      if (m_rsp) begin
        chk("rnd_rsp_err", rsp_err, m_err);
        chk("rnd_rsp_rdata", rsp_rdata, m_rd);
      end
      chk("rnd_resumeack", resumeack_o, m_ack);
      chk("rnd_haltto", haltto_o, (m_wait >= 15) ? 1 : 0);

      m_rsp_n = 0; m_err_n = m_err; m_rd_n = m_rd;
      if (m_incmd) begin
        m_rsp_n = 1;
        m_err_n = csr_err(m_cw, m_creg);
        m_rd_n  = (m_err_n == 0 && !m_cw) ? csr_rdata : 64'h0;
      end else if (cmd_valid && m_mode != 1) begin
        m_rsp_n = 1; m_err_n = 4; m_rd_n = 0;
      end
      if (!haltreq) m_wait = 0;
      else if (m_mode == 0 && !halted_i && m_wait < 15) m_wait++;
      if (m_incmd) begin
        if (e_edge) m_pend = 1;
      end else if (m_mode == 1) begin
        if (cmd_valid) begin
          if (e_edge) m_pend = 1;
        end else if (e_resume || !m_rsp) begin
          m_pend = 0;
        end
      end else begin
        m_pend = 0;
      end
      if (e_resume) m_ack = 0;
      else if (m_mode == 2 && run_i) m_ack = 1;
      if (m_incmd) begin
        m_incmd = 0;
      end else if (m_mode == 1) begin
        if (cmd_valid) begin
          m_incmd = 1; m_cw = cmd_write; m_creg = cmd_regno; m_cwd = cmd_wdata;
        end else if (e_resume) begin
          m_mode = 2;
        end
      end else if (m_mode == 0) begin
        if (halted_i) m_mode = 1;
      end else begin
        if (run_i) m_mode = 0;
      end
      m_rsp = m_rsp_n; m_err = m_err_n; m_rd = m_rd_n;
      m_prev = resumereq;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
